mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage data-memory access unit between the EX/MEM register (upstream) and the MEM/WB register (downstream).
//  Performs lw/lh/lhu/lb/lbu/sw/sh/sb over a req/ack data-memory bus: byte-lane steering, load extraction/extension, timeout.
//  Stalls the upstream pipeline while an access is outstanding and presents a bubble to MEM/WB until load data is ready.
// PARAMETERS
//  TIMEOUT  16  cycles in BUSY without dmem_ack before abort; legal 2..255; 8-bit wait counter
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-low reset
//  MemRead_in     in   1   load request (EX/MEM)
//  MemWrite_in    in   1   store request (EX/MEM); wins over MemRead_in if both set
//  RegWrite_in    in   1   writeback enable (EX/MEM)
//  MemtoReg_in    in   1   writeback select (EX/MEM)
//  size_in        in   2   00 byte, 01 half, 10 word, 11 treated as word
//  sign_ext_in    in   1   1: sign-extend loaded byte/half; 0: zero-extend
//  alu_result_in  in   32  effective address / ALU result
//  wd_in          in   32  store data (rt)
//  rfile_wn_in    in   5   destination register number
//  dmem_req       out  1   memory request, registered
//  dmem_we        out  1   1 store, 0 load; valid while dmem_req=1
//  dmem_addr      out  32  {alu_result_in[31:2],2'b00}
//  dmem_be        out  4   byte enables; lane n = bits 8n+7:8n (little-endian)
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_ack       in   1   one-cycle completion; dmem_rdata valid with it
//  dmem_rdata     in   32  read word
//  stall_out      out  1   1: EX/MEM and earlier stages hold
//  RegWrite_out   out  1   to MEM/WB; 0 = bubble
//  MemtoReg_out   out  1   to MEM/WB
//  alu_result_out out  32  to MEM/WB, = alu_result_in
//  rfile_wn_out   out  5   to MEM/WB, = rfile_wn_in
//  rd_out         out  32  to MEM/WB, extended load data
//  misalign_err   out  1   pulse: misaligned access dropped
//  bus_err        out  1   pulse: access aborted on timeout
// BEHAVIOUR
//  - Upstream holds all *_in stable while stall_out=1. mem_op = MemRead_in|MemWrite_in.
//  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//  - Reset (rst=0 at edge): state IDLE, dmem_req=0, wait counter=0, load register=0.
//    Outputs then: stall_out=0, dmem_req=0, errors 0, rd_out=0, RegWrite_out=0.
//    Reset during BUSY abandons the access; a late dmem_ack is ignored.
//  - FSM IDLE->BUSY->DONE->IDLE:
//    IDLE, no mem_op: zero-latency pass-through; RegWrite/MemtoReg/alu_result/wn follow inputs; rd_out=0; stall_out=0.
//    IDLE, misaligned mem_op: no request; stall_out=0, RegWrite_out=0, misalign_err=1 this cycle; stay IDLE.
//    IDLE, aligned mem_op: stall_out=1, RegWrite_out=0. Next edge: BUSY, dmem_req=1, counter=0.
//    BUSY: stall_out=1, RegWrite_out=0; dmem_req/we/addr/be/wdata held.
//      dmem_ack=1 -> next edge: DONE, dmem_req=0, extracted load data captured.
//      No ack, counter=TIMEOUT-1 -> next edge: DONE with abort flag, dmem_req=0.
//      Otherwise counter+1.
//    DONE: stall_out=0; outputs driven from inputs plus the captured data for one cycle; next edge IDLE.
//      MEM/WB samples them at that edge.
//      Normal load: rd_out = captured data.
//      Abort: RegWrite_out=0, bus_err=1.
//  - Minimum mem-op latency: 3 cycles (ack in first BUSY cycle). dmem_ack outside BUSY is ignored.
//  - Stores: byte -> wdata={4{wd[7:0]}}, be=1<<addr[1:0]; half -> {2{wd[15:0]}}, be=addr[1]?1100:0011; word -> be=1111.
//  - Loads: dmem_be=1111; lane selected by addr[1:0]/addr[1]; byte/half sign- or zero-extended per sign_ext_in.
//  - Store completion: RegWrite_out=RegWrite_in (normally 0), rd_out=0.
// TESTING
//  1 lw addr 0x100, ack 1st BUSY cycle, rdata 0xDEADBEEF -> stall 2 cycles; DONE rd_out=0xDEADBEEF, RegWrite_out=1.
//  2 lb addr 0x103, sign_ext=1, rdata 0x80FF_FF7F -> rd_out 0xFFFFFF80; lbu -> 0x00000080.
//  3 sh addr 0x102, wd 0x1234ABCD -> dmem_be 1100, dmem_wdata 0xABCDABCD, dmem_we=1.
//  4 lw addr 0x101 -> no dmem_req; misalign_err=1 one cycle; RegWrite_out=0; stall_out=0.
//  5 lw, no ack -> 16 BUSY cycles, then DONE with bus_err=1, RegWrite_out=0; ack 3 cycles later ignored.
//  6 rst=0 in 3rd BUSY cycle -> next edge dmem_req=0, IDLE, stall_out=0; add (no mem_op) passes with RegWrite_out=1.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: drives a req/ack bus for loads and stores,
// steers byte lanes, extends load data and stalls upstream while an access is outstanding.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic [1:0]  size_in,
    input  logic        sign_ext_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] wd_in,
    input  logic [4:0]  rfile_wn_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rfile_wn_out,
    output logic [31:0] rd_out,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  wait_cnt;
    logic [31:0] load_data;
    logic        abort;

    logic        mem_op;
    logic        misaligned;
    logic        start;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    assign mem_op = MemRead_in | MemWrite_in;
    assign start  = mem_op & ~misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (size_in)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_result_in[0];
            default: misaligned = (alu_result_in[1:0] != 2'b00);
        endcase
    end

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wd_in;
        if (MemWrite_in) begin
            case (size_in)
                2'b00: begin
                    st_be    = 4'b0001 << alu_result_in[1:0];
                    st_wdata = {4{wd_in[7:0]}};
                end
                2'b01: begin
                    st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{wd_in[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lane_byte = dmem_rdata[7:0];
        case (alu_result_in[1:0])
            2'b00: lane_byte = dmem_rdata[7:0];
            2'b01: lane_byte = dmem_rdata[15:8];
            2'b10: lane_byte = dmem_rdata[23:16];
            2'b11: lane_byte = dmem_rdata[31:24];
        endcase
        lane_half = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_in)
            2'b00:   load_ext = sign_ext_in ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
            2'b01:   load_ext = sign_ext_in ? {{16{lane_half[15]}}, lane_half} : {16'd0, lane_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = BUSY;
            BUSY:    if (dmem_ack || (wait_cnt == WAIT_LAST)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus request and captured data; bus fields are latched at issue and held through BUSY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            wait_cnt   <= 8'd0;
            load_data  <= 32'd0;
            abort      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite_in;
                        dmem_addr  <= {alu_result_in[31:2], 2'b00};
                        dmem_be    <= st_be;
                        dmem_wdata <= st_wdata;
                        wait_cnt   <= 8'd0;
                        abort      <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        load_data <= MemWrite_in ? 32'd0 : load_ext;
                    end else if (wait_cnt == WAIT_LAST) begin
                        dmem_req <= 1'b0;
                        abort    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign MemtoReg_out   = MemtoReg_in;
    assign alu_result_out = alu_result_in;
    assign rfile_wn_out   = rfile_wn_in;

    always_comb begin
        stall_out    = 1'b0;
        RegWrite_out = 1'b0;
        rd_out       = 32'd0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        case (state)
            IDLE: begin
                if (!mem_op) begin
                    RegWrite_out = RegWrite_in;
                end else if (misaligned) begin
                    misalign_err = 1'b1;
                end else begin
                    stall_out = 1'b1;
                end
            end
            BUSY: stall_out = 1'b1;
            DONE: begin
                if (abort) begin
                    bus_err = 1'b1;
                end else begin
                    RegWrite_out = RegWrite_in;
                    rd_out       = MemWrite_in ? 32'd0 : load_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a scoreboard queue holds the expected
// MEM/WB view of each instruction and is popped when the stage releases it.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
    logic [1:0]  size_in;
    logic        sign_ext_in;
    logic [31:0] alu_result_in, wd_in;
    logic [4:0]  rfile_wn_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_out, RegWrite_out, MemtoReg_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rfile_wn_out;
    logic [31:0] rd_out;
    logic        misalign_err, bus_err;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .size_in(size_in), .sign_ext_in(sign_ext_in),
        .alu_result_in(alu_result_in), .wd_in(wd_in), .rfile_wn_in(rfile_wn_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .alu_result_out(alu_result_out), .rfile_wn_out(rfile_wn_out), .rd_out(rd_out),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rw;
        logic        mtr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wn;
        logic        bus;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setInputs(input logic mr, input logic mw, input logic rw, input logic [1:0] size,
                             input logic sx, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] wn);
        MemRead_in    = mr;
        MemWrite_in   = mw;
        RegWrite_in   = rw;
        MemtoReg_in   = mr;
        size_in       = size;
        sign_ext_in   = sx;
        alu_result_in = addr;
        wd_in         = wd;
        rfile_wn_in   = wn;
    endtask

    task automatic pushExpected(input string tag, input logic mr, input logic [31:0] addr,
                                input logic [4:0] wn, input logic exp_rw, input logic [31:0] exp_rd,
                                input logic exp_bus, input logic exp_mis);
        exp_t e;
        e.tag = tag; e.rw = exp_rw; e.mtr = mr; e.rd = exp_rd;
        e.alu = addr; e.wn = wn; e.bus = exp_bus; e.mis = exp_mis;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input string tag, input logic mr, input logic mw, input logic rw,
                                 input logic [1:0] size, input logic sx, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [4:0] wn, input logic exp_rw,
                                 input logic [31:0] exp_rd, input logic exp_bus, input logic exp_mis);
        @(posedge clk); #1;
        setInputs(mr, mw, rw, size, sx, addr, wd, wn);
        pushExpected(tag, mr, addr, wn, exp_rw, exp_rd, exp_bus, exp_mis);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".stall"},    32'(stall_out),      32'd0);
            cmp({e.tag, ".regwrite"}, 32'(RegWrite_out),   32'(e.rw));
            cmp({e.tag, ".memtoreg"}, 32'(MemtoReg_out),   32'(e.mtr));
            cmp({e.tag, ".rd"},       rd_out,              e.rd);
            cmp({e.tag, ".alu"},      alu_result_out,      e.alu);
            cmp({e.tag, ".wn"},       32'(rfile_wn_out),   32'(e.wn));
            cmp({e.tag, ".bus_err"},  32'(bus_err),        32'(e.bus));
            cmp({e.tag, ".misalign"}, 32'(misalign_err),   32'(e.mis));
        end
    endtask

    // Runs one issued access to completion; ack_cycle is the BUSY cycle index that gets dmem_ack (-1: none).
    task automatic doAccess(input string tag, input int ack_cycle, input logic [31:0] rdata,
                            input logic exp_we, input logic [3:0] exp_be, input logic chk_wd,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_addr, input int exp_busy);
        int busy = 0;
        bit done = 1'b0;
        @(negedge clk);
        cmp({tag, ".stall_issue"}, 32'(stall_out),    32'd1);
        cmp({tag, ".req_issue"},   32'(dmem_req),     32'd0);
        cmp({tag, ".rw_issue"},    32'(RegWrite_out), 32'd0);
        for (int i = 0; i < 64 && !done; i++) begin
            @(posedge clk); #1;
            if (!stall_out) begin
                done = 1'b1;
            end else begin
                if (busy == 0) begin
                    cmp({tag, ".req"},  32'(dmem_req), 32'd1);
                    cmp({tag, ".we"},   32'(dmem_we),  32'(exp_we));
                    cmp({tag, ".be"},   32'(dmem_be),  32'(exp_be));
                    cmp({tag, ".addr"}, dmem_addr,     exp_addr);
                    if (chk_wd) cmp({tag, ".wdata"}, dmem_wdata, exp_wdata);
                end else begin
                    cmp({tag, ".req_held"}, 32'(dmem_req), 32'd1);
                end
                dmem_ack   = (busy == ack_cycle);
                dmem_rdata = rdata;
                busy++;
            end
        end
        dmem_ack = 1'b0;
        cmp({tag, ".completed"},   32'(done),     32'd1);
        cmp({tag, ".busy_cycles"}, 32'(busy),     32'(exp_busy));
        cmp({tag, ".req_done"},    32'(dmem_req), 32'd0);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        setInputs(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.stall",    32'(stall_out),    32'd0);
        cmp("reset.req",      32'(dmem_req),     32'd0);
        cmp("reset.regwrite", 32'(RegWrite_out), 32'd0);
        cmp("reset.rd",       rd_out,            32'd0);
        cmp("reset.bus_err",  32'(bus_err),      32'd0);
        cmp("reset.misalign", 32'(misalign_err), 32'd0);
        rst = 1'b1;

        applyStimulus("add0", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0055, 32'd0, 5'd9, 1'b1, 32'd0, 1'b0, 1'b0);
        @(negedge clk); checkOutput();

        applyStimulus("lw", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 5'd3, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        doAccess("lw", 0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 1'b0, 32'd0, 32'h0000_0100, 1);

        applyStimulus("lb", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 5'd4, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        doAccess("lb", 2, 32'h80FF_FF7F, 1'b0, 4'b1111, 1'b0, 32'd0, 32'h0000_0100, 3);

        applyStimulus("lbu", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 5'd5, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        doAccess("lbu", 0, 32'h80FF_FF7F, 1'b0, 4'b1111, 1'b0, 32'd0, 32'h0000_0100, 1);

        applyStimulus("lb_pos", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0100, 32'd0, 5'd5, 1'b1, 32'h0000_007F, 1'b0, 1'b0);
        doAccess("lb_pos", 0, 32'h80FF_FF7F, 1'b0, 4'b1111, 1'b0, 32'd0, 32'h0000_0100, 1);

        applyStimulus("lh", 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0102, 32'd0, 5'd6, 1'b1, 32'hFFFF_80FF, 1'b0, 1'b0);
        doAccess("lh", 1, 32'h80FF_FF7F, 1'b0, 4'b1111, 1'b0, 32'd0, 32'h0000_0100, 2);

        applyStimulus("lhu", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'd0, 5'd6, 1'b1, 32'h0000_FF7F, 1'b0, 1'b0);
        doAccess("lhu", 0, 32'h80FF_FF7F, 1'b0, 4'b1111, 1'b0, 32'd0, 32'h0000_0100, 1);

        applyStimulus("sh", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        doAccess("sh", 0, 32'hFFFF_FFFF, 1'b1, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0000_0100, 1);

        applyStimulus("sb", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_ABCD, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        doAccess("sb", 1, 32'hFFFF_FFFF, 1'b1, 4'b0010, 1'b1, 32'hCDCD_CDCD, 32'h0000_0100, 2);

        applyStimulus("sw", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h1234_ABCD, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        doAccess("sw", 0, 32'hFFFF_FFFF, 1'b1, 4'b1111, 1'b1, 32'h1234_ABCD, 32'h0000_0104, 1);

        applyStimulus("rdwr", 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0108, 32'h0BAD_F00D, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        doAccess("rdwr", 0, 32'hFFFF_FFFF, 1'b1, 4'b1111, 1'b1, 32'h0BAD_F00D, 32'h0000_0108, 1);

        applyStimulus("lw_mis", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'd0, 5'd7, 1'b0, 32'd0, 1'b0, 1'b1);
        @(negedge clk); cmp("lw_mis.req", 32'(dmem_req), 32'd0); checkOutput();

        applyStimulus("sh_mis", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h5555_AAAA, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        @(negedge clk); cmp("sh_mis.req", 32'(dmem_req), 32'd0); checkOutput();

        applyStimulus("add1", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0066, 32'd0, 5'd10, 1'b1, 32'd0, 1'b0, 1'b0);
        @(negedge clk); cmp("add1.req", 32'(dmem_req), 32'd0); checkOutput();

        applyStimulus("lw_tmo", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'd0, 5'd8, 1'b0, 32'd0, 1'b1, 1'b0);
        doAccess("lw_tmo", -1, 32'h1111_1111, 1'b0, 4'b1111, 1'b0, 32'd0, 32'h0000_0200, 16);

        applyStimulus("add2", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0070, 32'd0, 5'd12, 1'b1, 32'd0, 1'b0, 1'b0);
        @(negedge clk); checkOutput();
        applyStimulus("add3", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0071, 32'd0, 5'd13, 1'b1, 32'd0, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h2222_2222;
        @(negedge clk); checkOutput();
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        cmp("late_ack.req",   32'(dmem_req),  32'd0);
        cmp("late_ack.stall", 32'(stall_out), 32'd0);
        cmp("late_ack.rd",    rd_out,         32'd0);

        setInputs(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 5'd4);
        @(negedge clk); cmp("rst_busy.stall_issue", 32'(stall_out), 32'd1);
        @(posedge clk); #1; cmp("rst_busy.req_b1", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        cmp("rst_busy.req_after", 32'(dmem_req), 32'd0);
        cmp("rst_busy.bus_err",   32'(bus_err),  32'd0);
        setInputs(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0077, 32'd0, 5'd11);
        pushExpected("add_after_rst", 1'b0, 32'h0000_0077, 5'd11, 1'b1, 32'd0, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h3333_3333;
        @(negedge clk); checkOutput();
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        cmp("rst_busy.req_late_ack", 32'(dmem_req),     32'd0);
        cmp("rst_busy.stall_final",  32'(stall_out),    32'd0);
        cmp("rst_busy.rw_final",     32'(RegWrite_out), 32'd1);

        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
